// File: rtl/mem_req_ctrl_pkg.sv
// Shared pipeline definitions for the data-memory request controller:
// FSM state encoding, access-size encodings and the default in-flight limit.
package mem_req_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } req_state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // SRAM transactions in flight plus the buffered response.
  localparam int MAX_OUTST_DEF = 2;

endpackage

// File: rtl/mem_req_ctrl.sv
// Data-SRAM request controller between EX and MEM. It accepts one access at
// a time from EX, issues it on the SRAM request channel, tracks issued but
// unanswered transactions as live or killed, and hands live responses to MEM
// through a one-entry buffer. A flush turns all live transactions into killed
// ones so their responses are silently discarded when they come back.
module mem_req_ctrl
  import mem_req_ctrl_pkg::*;
#(
  parameter int MAX_OUTST = MAX_OUTST_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_req_valid,
  input  logic        ex_req_wr,
  input  logic [1:0]  ex_req_size,
  input  logic [31:0] ex_req_addr,
  input  logic [3:0]  ex_req_wstrb,
  input  logic [31:0] ex_req_wdata,
  output logic        ex_req_ready,
  input  logic        flush,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [31:0] data_sram_addr,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        mem_resp_valid,
  output logic        mem_resp_wr,
  output logic [31:0] mem_resp_rdata,
  input  logic        mem_resp_ready
);

  localparam logic [2:0] MAX_OUTST_W = 3'(MAX_OUTST);

  req_state_t  state, state_next;

  logic        req_wr_reg;
  logic [1:0]  req_size_reg;
  logic [31:0] req_addr_reg;
  logic [3:0]  req_wstrb_reg;
  logic [31:0] req_wdata_reg;

  logic [1:0]  live_cnt, live_next, live_left;
  logic [1:0]  kill_cnt, kill_next, kill_left;
  logic        req_kill, req_kill_next;

  // wr flag of each live transaction, bit 0 = oldest live one. Killed
  // transactions are always older than live ones, so the oldest live entry
  // is the one answered by the next data_ok once kill_cnt reaches zero.
  logic [3:0]  wr_q, wr_q_next;

  logic        buf_valid, buf_wr;
  logic [31:0] buf_rdata;

  logic [2:0]  occupancy;
  logic        accept, aok, dok_kill, dok_live;

  assign occupancy    = {1'b0, live_cnt} + {1'b0, kill_cnt} + {2'b00, buf_valid};
  assign ex_req_ready = (state == ST_IDLE) & ~flush & (occupancy < MAX_OUTST_W);
  assign accept       = ex_req_valid & ex_req_ready;
  assign aok          = (state == ST_REQ) & data_sram_addr_ok;
  assign dok_kill     = data_sram_data_ok & (kill_cnt != 2'd0);
  assign dok_live     = data_sram_data_ok & (kill_cnt == 2'd0) & (live_cnt != 2'd0);

  assign data_sram_req   = (state == ST_REQ);
  assign data_sram_wr    = req_wr_reg;
  assign data_sram_size  = req_size_reg;
  assign data_sram_addr  = req_addr_reg;
  assign data_sram_wstrb = req_wstrb_reg;
  assign data_sram_wdata = req_wdata_reg;

  assign mem_resp_valid = buf_valid;
  assign mem_resp_wr    = buf_wr;
  assign mem_resp_rdata = buf_rdata;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next state: leave IDLE on acceptance, leave REQ only on addr_ok (flush
  // never withdraws a request already presented to the SRAM).
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_REQ;
      ST_REQ:  if (data_sram_addr_ok) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Counter, kill-flag and live-wr bookkeeping for this cycle's events.
  always_comb begin
    live_left     = live_cnt - {1'b0, dok_live};
    kill_left     = kill_cnt - {1'b0, dok_kill};
    live_next     = live_left;
    kill_next     = kill_left;
    req_kill_next = 1'b0;
    wr_q_next     = dok_live ? (wr_q >> 1) : wr_q;
    if (flush) begin
      // Everything still live, including a request handshaking right now,
      // becomes killed.
      kill_next = kill_left + live_left + {1'b0, aok};
      live_next = 2'd0;
    end else if (aok && req_kill) begin
      kill_next = kill_left + 2'd1;
    end else if (aok) begin
      live_next            = live_left + 2'd1;
      wr_q_next[live_left] = req_wr_reg;
    end
    if (state == ST_REQ && !data_sram_addr_ok)
      req_kill_next = req_kill | flush;
  end

  // Sequential update of counters and kill tracking.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      live_cnt <= 2'd0;
      kill_cnt <= 2'd0;
      req_kill <= 1'b0;
      wr_q     <= 4'd0;
    end else begin
      live_cnt <= live_next;
      kill_cnt <= kill_next;
      req_kill <= req_kill_next;
      wr_q     <= wr_q_next;
    end
  end

  // Capture the accepted access; these registers feed the SRAM channel.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      req_wr_reg    <= 1'b0;
      req_size_reg  <= SZ_B;
      req_addr_reg  <= 32'd0;
      req_wstrb_reg <= 4'd0;
      req_wdata_reg <= 32'd0;
    end else if (accept) begin
      req_wr_reg    <= ex_req_wr;
      req_size_reg  <= ex_req_size;
      req_addr_reg  <= ex_req_addr;
      req_wstrb_reg <= ex_req_wstrb;
      req_wdata_reg <= ex_req_wdata;
    end
  end

  // One-entry response buffer: flush empties it, a live response refills it
  // (winning over a same-cycle consume), otherwise MEM drains it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      buf_valid <= 1'b0;
      buf_wr    <= 1'b0;
      buf_rdata <= 32'd0;
    end else if (flush) begin
      buf_valid <= 1'b0;
    end else if (dok_live) begin
      buf_valid <= 1'b1;
      buf_wr    <= wr_q[0];
      buf_rdata <= data_sram_rdata;
    end else if (mem_resp_ready) begin
      buf_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl: directed scenarios followed by a
// randomized run against a transaction-level reference model.
module tb_mem_req_ctrl;
  import mem_req_ctrl_pkg::*;

  localparam int MAX_OUTST = 2;

  logic        clk;
  logic        resetn;
  logic        ex_req_valid;
  logic        ex_req_wr;
  logic [1:0]  ex_req_size;
  logic [31:0] ex_req_addr;
  logic [3:0]  ex_req_wstrb;
  logic [31:0] ex_req_wdata;
  logic        ex_req_ready;
  logic        flush;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        mem_resp_valid;
  logic        mem_resp_wr;
  logic [31:0] mem_resp_rdata;
  logic        mem_resp_ready;

  int n_cmp = 0;
  int n_bad = 0;

  mem_req_ctrl #(.MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .resetn(resetn),
    .ex_req_valid(ex_req_valid), .ex_req_wr(ex_req_wr), .ex_req_size(ex_req_size),
    .ex_req_addr(ex_req_addr), .ex_req_wstrb(ex_req_wstrb), .ex_req_wdata(ex_req_wdata),
    .ex_req_ready(ex_req_ready), .flush(flush),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_addr(data_sram_addr), .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_wr(mem_resp_wr), .mem_resp_rdata(mem_resp_rdata),
    .mem_resp_ready(mem_resp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    ex_req_valid = 0; ex_req_wr = 0; ex_req_size = SZ_W; ex_req_addr = 0;
    ex_req_wstrb = 0; ex_req_wdata = 0; flush = 0; data_sram_addr_ok = 0;
    data_sram_data_ok = 0; data_sram_rdata = 0; mem_resp_ready = 0;
  endtask

  // Present one access to EX for a single cycle.
  task automatic present(input logic wr, input logic [31:0] addr, input logic [3:0] wstrb,
                         input logic [31:0] wdata);
    ex_req_valid = 1; ex_req_wr = wr; ex_req_size = SZ_W; ex_req_addr = addr;
    ex_req_wstrb = wstrb; ex_req_wdata = wdata;
    tick();
    ex_req_valid = 0;
  endtask

  task automatic do_reset();
    quiet_inputs();
    resetn = 0;
    tick(); tick();
    resetn = 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (data_sram_req !== 1'b0) begin n_bad++; $display("FAIL reset_sram_req: got %b want 0", data_sram_req); end
    n_cmp++; if (mem_resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid: got %b want 0", mem_resp_valid); end
    n_cmp++; if ({data_sram_addr, data_sram_wdata, data_sram_wstrb} !== 68'd0) begin n_bad++; $display("FAIL reset_sram_data: got %h/%h/%h want 0", data_sram_addr, data_sram_wdata, data_sram_wstrb); end
    n_cmp++; if (mem_resp_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_resp_rdata: got %h want 0", mem_resp_rdata); end
    #1;
    n_cmp++; if (ex_req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ex_req_ready); end
    $display("test_reset done");
  endtask

  task automatic test_word_load();
    int seen;
    ex_req_valid = 1; ex_req_wr = 0; ex_req_size = SZ_W; ex_req_addr = 32'h1000; ex_req_wstrb = 0;
    #1;
    n_cmp++; if (ex_req_ready !== 1'b1) begin n_bad++; $display("FAIL load_ready: got %b want 1", ex_req_ready); end
    tick();
    ex_req_valid = 0;
    n_cmp++; if (data_sram_req !== 1'b1 || data_sram_addr !== 32'h1000 || data_sram_size !== SZ_W || data_sram_wr !== 1'b0) begin
      n_bad++; $display("FAIL load_issue: got req=%b addr=%h size=%b wr=%b want 1/00001000/10/0", data_sram_req, data_sram_addr, data_sram_size, data_sram_wr); end
    data_sram_addr_ok = 1;
    tick();
    data_sram_addr_ok = 0;
    n_cmp++; if (data_sram_req !== 1'b0) begin n_bad++; $display("FAIL load_req_drop: got %b want 0", data_sram_req); end
    data_sram_data_ok = 1; data_sram_rdata = 32'hDEADBEEF;
    tick();
    data_sram_data_ok = 0; data_sram_rdata = 0;
    n_cmp++; if (mem_resp_valid !== 1'b1 || mem_resp_rdata !== 32'hDEADBEEF || mem_resp_wr !== 1'b0) begin
      n_bad++; $display("FAIL load_resp: got v=%b d=%h wr=%b want 1/deadbeef/0", mem_resp_valid, mem_resp_rdata, mem_resp_wr); end
    seen = mem_resp_valid ? 1 : 0;
    mem_resp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mem_resp_valid) seen++;
    end
    mem_resp_ready = 0;
    n_cmp++; if (seen !== 1) begin n_bad++; $display("FAIL load_resp_once: got %0d cycles want 1", seen); end
    $display("test_word_load done: rdata=deadbeef");
  endtask

  task automatic test_flush_stall();
    int bad_hold;
    int vseen;
    bad_hold = 0;
    present(1'b0, 32'h2000, 4'h0, 32'h0);
    for (int c = 0; c < 5; c++) begin
      if (data_sram_req !== 1'b1 || data_sram_addr !== 32'h2000) bad_hold++;
      flush = (c == 1);
      tick();
    end
    flush = 0;
    n_cmp++; if (bad_hold !== 0) begin n_bad++; $display("FAIL stall_hold: got %0d unstable cycles want 0", bad_hold); end
    n_cmp++; if (data_sram_req !== 1'b1 || data_sram_addr !== 32'h2000) begin n_bad++; $display("FAIL stall_before_aok: got req=%b addr=%h want 1/00002000", data_sram_req, data_sram_addr); end
    data_sram_addr_ok = 1;
    tick();
    data_sram_addr_ok = 0;
    data_sram_data_ok = 1; data_sram_rdata = 32'hBAD0BAD0;
    tick();
    data_sram_data_ok = 0; data_sram_rdata = 0;
    vseen = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_resp_valid) vseen++;
      tick();
    end
    n_cmp++; if (vseen !== 0) begin n_bad++; $display("FAIL stall_killed_resp: got %0d valid cycles want 0", vseen); end
    n_cmp++; if (ex_req_ready !== 1'b1) begin n_bad++; $display("FAIL stall_ready_after: got %b want 1", ex_req_ready); end
    $display("test_flush_stall done");
  endtask

  task automatic test_back_to_back();
    mem_resp_ready = 0;
    present(1'b0, 32'h4000, 4'h0, 32'h0);
    data_sram_addr_ok = 1;
    tick();
    data_sram_addr_ok = 0;
    ex_req_valid = 1; ex_req_addr = 32'h4004; ex_req_wr = 0;
    data_sram_data_ok = 1; data_sram_rdata = 32'h11111111;
    #1;
    n_cmp++; if (ex_req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_second_ready: got %b want 1", ex_req_ready); end
    tick();
    ex_req_valid = 0; data_sram_data_ok = 0; data_sram_rdata = 0;
    n_cmp++; if (data_sram_addr !== 32'h4004 || data_sram_req !== 1'b1) begin n_bad++; $display("FAIL b2b_second_issue: got req=%b addr=%h want 1/00004004", data_sram_req, data_sram_addr); end
    data_sram_addr_ok = 1;
    tick();
    data_sram_addr_ok = 0;
    ex_req_valid = 1; ex_req_addr = 32'h4008;
    #1;
    n_cmp++; if (ex_req_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_full_ready: got %b want 0", ex_req_ready); end
    tick(); tick(); tick();
    ex_req_valid = 0;
    n_cmp++; if (mem_resp_valid !== 1'b1 || mem_resp_rdata !== 32'h11111111 || data_sram_req !== 1'b0) begin
      n_bad++; $display("FAIL b2b_hold: got v=%b d=%h req=%b want 1/11111111/0", mem_resp_valid, mem_resp_rdata, data_sram_req); end
    mem_resp_ready = 1;
    tick();
    mem_resp_ready = 0;
    n_cmp++; if (mem_resp_valid !== 1'b0 || ex_req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_drain: got v=%b ready=%b want 0/1", mem_resp_valid, ex_req_ready); end
    data_sram_data_ok = 1; data_sram_rdata = 32'h22222222;
    tick();
    data_sram_data_ok = 0; data_sram_rdata = 0;
    n_cmp++; if (mem_resp_valid !== 1'b1 || mem_resp_rdata !== 32'h22222222) begin n_bad++; $display("FAIL b2b_second_resp: got v=%b d=%h want 1/22222222", mem_resp_valid, mem_resp_rdata); end
    mem_resp_ready = 1;
    tick();
    mem_resp_ready = 0;
    $display("test_back_to_back done");
  endtask

  task automatic test_flush_live2();
    int vseen;
    mem_resp_ready = 1;
    present(1'b0, 32'h5000, 4'h0, 32'h0);
    data_sram_addr_ok = 1; tick(); data_sram_addr_ok = 0;
    present(1'b0, 32'h5004, 4'h0, 32'h0);
    data_sram_addr_ok = 1; tick(); data_sram_addr_ok = 0;
    n_cmp++; if (ex_req_ready !== 1'b0) begin n_bad++; $display("FAIL live2_ready: got %b want 0", ex_req_ready); end
    flush = 1;
    tick();
    flush = 0;
    n_cmp++; if (ex_req_ready !== 1'b0) begin n_bad++; $display("FAIL kill2_ready: got %b want 0", ex_req_ready); end
    vseen = 0;
    data_sram_data_ok = 1; data_sram_rdata = 32'hAAAA0001; tick(); if (mem_resp_valid) vseen++;
    data_sram_rdata = 32'hAAAA0002; tick(); if (mem_resp_valid) vseen++;
    data_sram_data_ok = 0; data_sram_rdata = 0;
    n_cmp++; if (vseen !== 0) begin n_bad++; $display("FAIL kill2_dropped: got %0d valid cycles want 0", vseen); end
    n_cmp++; if (ex_req_ready !== 1'b1) begin n_bad++; $display("FAIL kill2_ready_after: got %b want 1", ex_req_ready); end
    present(1'b0, 32'h5008, 4'h0, 32'h0);
    data_sram_addr_ok = 1; tick(); data_sram_addr_ok = 0;
    data_sram_data_ok = 1; data_sram_rdata = 32'h33333333; tick();
    data_sram_data_ok = 0; data_sram_rdata = 0;
    n_cmp++; if (mem_resp_valid !== 1'b1 || mem_resp_rdata !== 32'h33333333) begin n_bad++; $display("FAIL kill2_third_resp: got v=%b d=%h want 1/33333333", mem_resp_valid, mem_resp_rdata); end
    tick();
    mem_resp_ready = 0;
    $display("test_flush_live2 done");
  endtask

  task automatic test_store();
    present(1'b1, 32'h3000, 4'b0011, 32'h12345678);
    n_cmp++; if (data_sram_wr !== 1'b1 || data_sram_wstrb !== 4'b0011 || data_sram_wdata !== 32'h12345678) begin
      n_bad++; $display("FAIL store_issue: got wr=%b strb=%b wdata=%h want 1/0011/12345678", data_sram_wr, data_sram_wstrb, data_sram_wdata); end
    data_sram_addr_ok = 1; tick(); data_sram_addr_ok = 0;
    data_sram_data_ok = 1; tick(); data_sram_data_ok = 0;
    n_cmp++; if (mem_resp_valid !== 1'b1 || mem_resp_wr !== 1'b1) begin n_bad++; $display("FAIL store_resp: got v=%b wr=%b want 1/1", mem_resp_valid, mem_resp_wr); end
    mem_resp_ready = 1; tick(); mem_resp_ready = 0;
    $display("test_store done");
  endtask

  task automatic test_spurious_data_ok();
    data_sram_data_ok = 1; data_sram_rdata = 32'h99999999;
    tick(); tick();
    data_sram_data_ok = 0; data_sram_rdata = 0;
    n_cmp++; if (mem_resp_valid !== 1'b0 || ex_req_ready !== 1'b1) begin n_bad++; $display("FAIL spurious_dok: got v=%b ready=%b want 0/1", mem_resp_valid, ex_req_ready); end
    present(1'b0, 32'h6000, 4'h0, 32'h0);
    data_sram_addr_ok = 1; tick(); data_sram_addr_ok = 0;
    data_sram_data_ok = 1; data_sram_rdata = 32'h55555555; tick();
    data_sram_data_ok = 0; data_sram_rdata = 0;
    n_cmp++; if (mem_resp_valid !== 1'b1 || mem_resp_rdata !== 32'h55555555) begin n_bad++; $display("FAIL spurious_then_load: got v=%b d=%h want 1/55555555", mem_resp_valid, mem_resp_rdata); end
    mem_resp_ready = 1; tick(); mem_resp_ready = 0;
    $display("test_spurious_data_ok done");
  endtask

  task automatic test_reset_mid();
    present(1'b0, 32'h7000, 4'h0, 32'h0);
    data_sram_addr_ok = 1; tick(); data_sram_addr_ok = 0;
    present(1'b1, 32'h7004, 4'hF, 32'hCAFEF00D);
    n_cmp++; if (data_sram_req !== 1'b1) begin n_bad++; $display("FAIL mid_in_req: got %b want 1", data_sram_req); end
    resetn = 0;
    tick();
    resetn = 1;
    n_cmp++; if (data_sram_req !== 1'b0 || data_sram_addr !== 32'd0 || mem_resp_valid !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_state: got req=%b addr=%h v=%b want 0/0/0", data_sram_req, data_sram_addr, mem_resp_valid); end
    #1;
    n_cmp++; if (ex_req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_reset_ready: got %b want 1", ex_req_ready); end
    present(1'b0, 32'h7008, 4'h0, 32'h0);
    data_sram_addr_ok = 1; tick(); data_sram_addr_ok = 0;
    data_sram_data_ok = 1; data_sram_rdata = 32'h66666666; tick();
    data_sram_data_ok = 0; data_sram_rdata = 0;
    n_cmp++; if (mem_resp_valid !== 1'b1 || mem_resp_rdata !== 32'h66666666) begin n_bad++; $display("FAIL mid_reset_after: got v=%b d=%h want 1/66666666", mem_resp_valid, mem_resp_rdata); end
    mem_resp_ready = 1; tick(); mem_resp_ready = 0;
    $display("test_reset_mid done");
  endtask

  // Reference model: an access is pending at the SRAM until addr_ok, then it
  // sits in an in-order queue of issued transactions until its data_ok. A
  // flush marks everything not yet answered as killed and empties MEM's buffer.
  typedef struct {
    logic        killed;
    logic        wr;
    logic [31:0] rdata;
  } txn_t;

  task automatic test_random();
    txn_t        sq[$];
    txn_t        t;
    logic        busy, cur_killed, cur_wr;
    logic [31:0] cur_addr, cur_wdata;
    logic        bv, bw;
    logic [31:0] bd;
    logic        exp_ready, deliver;
    int          n_acc;
    do_reset();
    busy = 0; cur_killed = 0; cur_wr = 0; cur_addr = 0; cur_wdata = 0;
    bv = 0; bw = 0; bd = 0; n_acc = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      n_cmp++; if (data_sram_req !== busy) begin n_bad++; $display("FAIL rnd_sram_req cyc %0d: got %b want %b", cyc, data_sram_req, busy); end
      if (busy) begin
        n_cmp++; if (data_sram_addr !== cur_addr || data_sram_wdata !== cur_wdata || data_sram_wr !== cur_wr) begin
          n_bad++; $display("FAIL rnd_sram_fields cyc %0d: got %h/%h/%b want %h/%h/%b", cyc, data_sram_addr, data_sram_wdata, data_sram_wr, cur_addr, cur_wdata, cur_wr); end
      end
      n_cmp++; if (mem_resp_valid !== bv) begin n_bad++; $display("FAIL rnd_resp_valid cyc %0d: got %b want %b", cyc, mem_resp_valid, bv); end
      if (bv) begin
        n_cmp++; if (mem_resp_rdata !== bd || mem_resp_wr !== bw) begin n_bad++; $display("FAIL rnd_resp_data cyc %0d: got %h/%b want %h/%b", cyc, mem_resp_rdata, mem_resp_wr, bd, bw); end
      end
      ex_req_valid = 1'($urandom_range(0, 1));
      ex_req_wr = 1'($urandom_range(0, 1));
      ex_req_size = 2'($urandom_range(0, 2));
      ex_req_addr = $urandom;
      ex_req_wstrb = 4'($urandom);
      ex_req_wdata = $urandom;
      flush = ($urandom_range(0, 11) == 0);
      mem_resp_ready = ($urandom_range(0, 2) != 0);
      data_sram_addr_ok = busy && ($urandom_range(0, 1) == 1);
      data_sram_data_ok = (sq.size() > 0) && ($urandom_range(0, 1) == 1);
      data_sram_rdata = data_sram_data_ok ? sq[0].rdata : $urandom;
      exp_ready = !busy && !flush && ((sq.size() + int'(bv)) < MAX_OUTST);
      #1;
      n_cmp++; if (ex_req_ready !== exp_ready) begin n_bad++; $display("FAIL rnd_ready cyc %0d: got %b want %b", cyc, ex_req_ready, exp_ready); end
      deliver = 0;
      if (data_sram_data_ok) begin
        t = sq.pop_front();
        deliver = !t.killed && !flush;
      end
      if (flush) foreach (sq[i]) sq[i].killed = 1'b1;
      if (data_sram_addr_ok) begin
        sq.push_back('{killed: cur_killed | flush, wr: cur_wr, rdata: $urandom});
        busy = 0;
      end else if (busy && flush) begin
        cur_killed = 1;
      end
      if (flush) bv = 0;
      else if (deliver) begin bv = 1; bw = t.wr; bd = t.rdata; end
      else if (mem_resp_ready) bv = 0;
      if (ex_req_valid && exp_ready) begin
        busy = 1; cur_killed = 0; cur_wr = ex_req_wr; cur_addr = ex_req_addr; cur_wdata = ex_req_wdata;
        n_acc++;
        $display("rnd txn %0d: wr=%b addr=%h", n_acc, ex_req_wr, ex_req_addr);
      end
      tick();
    end
    quiet_inputs();
    $display("test_random done: %0d accesses", n_acc);
  endtask

  initial begin
    resetn = 0;
    quiet_inputs();
    test_reset();
    test_word_load();
    test_flush_stall();
    test_back_to_back();
    test_flush_live2();
    test_store();
    test_spurious_data_ok();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_req_ctrl.md
MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 SHALL have parameter MAX_OUTST, default 2, max data-SRAM transactions in flight plus buffered responses.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- ex_req_valid  in  1  EX presents a memory access
- ex_req_wr  in  1  1 = store
- ex_req_size  in  2  00 byte, 01 half, 10 word
- ex_req_addr  in  32  byte address
- ex_req_wstrb  in  4  store byte enables
- ex_req_wdata  in  32  store data
- ex_req_ready  out  1  access accepted this cycle
- flush  in  1  wb_ex | ertn_flush; cancels all younger accesses
- data_sram_req  out  1  SRAM request valid
- data_sram_wr  out  1  SRAM write
- data_sram_size  out  2  SRAM size
- data_sram_addr  out  32  SRAM address
- data_sram_wstrb  out  4  SRAM byte enables
- data_sram_wdata  out  32  SRAM write data
- data_sram_addr_ok  in  1  request handshake complete
- data_sram_data_ok  in  1  response returned, in order
- data_sram_rdata  in  32  response data
- mem_resp_valid  out  1  completed access available to MEM
- mem_resp_wr  out  1  completed access was a store
- mem_resp_rdata  out  32  load data
- mem_resp_ready  in  1  MEM consumes response (mem_allowin)

Function
REQ-003 SHALL implement FSM IDLE/REQ: IDLE->REQ on ex_req_valid & ex_req_ready; REQ->IDLE on data_sram_addr_ok.
REQ-004 SHALL drive ex_req_ready = (state==IDLE) & ~flush & (live_cnt+kill_cnt+buf_valid < MAX_OUTST).
REQ-005 SHALL capture wr/size/addr/wstrb/wdata on acceptance and drive data_sram_* from those registers, with data_sram_req=1 exactly while in REQ, starting the cycle after acceptance.
REQ-006 SHALL hold all data_sram_* outputs stable in REQ until addr_ok and never deassert data_sram_req before addr_ok, including on flush.
REQ-007 SHALL keep 2-bit counters live_cnt and kill_cnt for issued, unanswered transactions; addr_ok increments live_cnt, or kill_cnt if req_kill is set.
REQ-008 SHALL on flush:
- add live_cnt to kill_cnt and clear live_cnt
- set req_kill if in REQ
- clear buf_valid
REQ-009 SHALL retire each data_ok as follows:
- kill_cnt>0: decrement kill_cnt, drop response
- otherwise: decrement live_cnt, write {wr, rdata} into the 1-entry response buffer and set buf_valid
REQ-010 SHALL drop a data_ok coinciding with flush; the remaining live transactions join kill_cnt per REQ-008.
REQ-011 SHALL ignore data_ok when live_cnt==kill_cnt==0, with counters saturating at 0.
REQ-012 SHALL drive mem_resp_valid=buf_valid and clear buf_valid on mem_resp_ready, unless data_ok delivers in the same cycle, in which case buf_valid remains set with the new data.
REQ-013 SHALL rely on REQ-004 so that a live data_ok never arrives while the buffer is full.
REQ-014 SHALL clear req_kill on leaving REQ.
REQ-015 SHALL complete a load in at least 2 cycles, acceptance to mem_resp_valid, when addr_ok and data_ok return the cycle after each is possible.

Reset
REQ-016 SHALL on ~resetn at posedge clk set:
- state=IDLE
- live_cnt=kill_cnt=0, buf_valid=0, req_kill=0
- data_sram_req=0, mem_resp_valid=0
- all captured registers and data outputs to 0
REQ-017 SHALL discard everything in flight on reset mid-operation; the SRAM model is reset concurrently.

Structure
REQ-018 SHALL take the state enum, size encodings (SZ_B=00, SZ_H=01, SZ_W=10) and the MAX_OUTST default from the shared pipeline package.
REQ-019 SHALL be a single module with no sub-modules; the response buffer is inline.

Verification
REQ-020 SHALL cover these directed scenarios:
- Word load at 0x1000, addr_ok and data_ok each next cycle, rdata 0xDEADBEEF -> mem_resp_valid with 0xDEADBEEF exactly once.
- addr_ok held low 5 cycles with flush in cycle 2 -> data_sram_req and addr stable all 5 cycles; resulting data_ok dropped; mem_resp_valid stays 0.
- Two back-to-back loads, mem_resp_ready=0 -> ex_req_ready=0 after the 2nd acceptance; first response held; draining restores ready.
- flush with live_cnt=2 -> kill_cnt=2; next two data_ok dropped; a third load's response is delivered.
- Store 0x12345678, wstrb 0011 -> data_sram_wr=1, wstrb=0011; mem_resp_valid, mem_resp_wr=1 after data_ok.
- resetn low while in REQ with live_cnt=1 -> next cycle IDLE, all counters 0, data_sram_req=0.
